// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the UART boot loader: loader and receiver
// state encodings, the frame header value and the fixed frame byte offsets.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CNT_LO,
    CNT_HI,
    DATA,
    CSUM,
    DONE,
    ERROR
  } state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_BITS,
    RX_STOP
  } rx_state_t;

  localparam logic [7:0] HDR_BYTE = 8'hA5;

  // Fixed positions inside a frame; the checksum follows the count*4 data bytes.
  localparam int OFS_HEADER = 0;
  localparam int OFS_CNT_LO = 1;
  localparam int OFS_CNT_HI = 2;
  localparam int OFS_DATA   = 3;

endpackage

// File: rtl/imem_uart_loader_if.sv
// Instruction-memory write port driven by the loader (master) and consumed
// by the core's instruction RAM (slave).
interface imem_uart_loader_if #(
  parameter int ADDR_WIDTH = 10
);
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [31:0]           wdata;

  modport master (output we, addr, wdata);
  modport slave  (input  we, addr, wdata);
endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, glitch rejection
// on the start bit, and one-cycle byte_valid / frame_err pulses.
module uart_rx_byte
  import imem_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic            sync1_reg, sync2_reg, prev_reg;
  rx_state_t       state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [2:0]      bit_reg, bit_next;
  logic [7:0]      shift_reg, shift_next;
  logic            valid_next, ferr_next;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_reg  <= 1'b1;
      sync2_reg  <= 1'b1;
      prev_reg   <= 1'b1;
      state_reg  <= RX_IDLE;
      cnt_reg    <= '0;
      bit_reg    <= '0;
      shift_reg  <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      sync1_reg  <= rx;
      sync2_reg  <= sync1_reg;
      prev_reg   <= sync2_reg;
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      bit_reg    <= bit_next;
      shift_reg  <= shift_next;
      byte_valid <= valid_next;
      frame_err  <= ferr_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg + 1'b1;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    valid_next = 1'b0;
    ferr_next  = 1'b0;
    case (state_reg)
      RX_IDLE: begin
        cnt_next = '0;
        if (prev_reg && !sync2_reg) state_next = RX_START;
      end
      RX_START: begin
        // A line back high at mid start bit was only a glitch.
        if (cnt_reg == HALF) begin
          cnt_next   = '0;
          bit_next   = '0;
          state_next = sync2_reg ? RX_IDLE : RX_BITS;
        end
      end
      RX_BITS: begin
        if (cnt_reg == LAST) begin
          cnt_next   = '0;
          shift_next = {sync2_reg, shift_reg[7:1]};
          bit_next   = bit_reg + 3'd1;
          if (bit_reg == 3'd7) state_next = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt_reg == LAST) begin
          cnt_next   = '0;
          state_next = RX_IDLE;
          valid_next = sync2_reg;
          ferr_next  = !sync2_reg;
        end
      end
      default: state_next = RX_IDLE;
    endcase
  end

  assign byte_data = shift_reg;

endmodule

// File: rtl/imem_uart_loader.sv
// Boot loader: parses A5/count/data/checksum frames from the UART, writes
// words to instruction memory and holds the core in reset until verified.
module imem_uart_loader
  import imem_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_WIDTH   = 10,
  parameter int MAX_WORDS    = 1024,
  parameter int TIMEOUT_CLKS = 1000000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  uart_rx,
  imem_uart_loader_if.master    imem,
  output logic                  cpu_reset_n,
  output logic                  load_done,
  output logic                  load_err,
  output logic [15:0]           words_loaded
);

  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CLKS);

  logic       byte_valid, frame_err;
  logic [7:0] byte_data;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk       (clk),
    .reset_n   (reset_n),
    .rx        (uart_rx),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .frame_err (frame_err)
  );

  state_t                state_reg, state_next;
  logic [15:0]           count_reg, count_next;
  logic [1:0]            idx_reg, idx_next;
  logic [31:0]           word_reg, word_next;
  logic [7:0]            acc_reg, acc_next;
  logic [15:0]           words_reg, words_next;
  logic [TW-1:0]         timer_reg, timer_next;
  logic                  we_reg, we_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [31:0]           wdata_reg, wdata_next;
  logic                  cpu_reg, cpu_next;
  logic                  done_reg, done_next;
  logic                  err_reg, err_next;
  logic [15:0]           count_full;
  logic                  active;

  assign count_full = {byte_data, count_reg[7:0]};
  assign active = (state_reg == CNT_LO) || (state_reg == CNT_HI) ||
                  (state_reg == DATA)   || (state_reg == CSUM);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      count_reg <= '0;
      idx_reg   <= '0;
      word_reg  <= '0;
      acc_reg   <= '0;
      words_reg <= '0;
      timer_reg <= '0;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      cpu_reg   <= 1'b0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      idx_reg   <= idx_next;
      word_reg  <= word_next;
      acc_reg   <= acc_next;
      words_reg <= words_next;
      timer_reg <= timer_next;
      we_reg    <= we_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      cpu_reg   <= cpu_next;
      done_reg  <= done_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    idx_next   = idx_reg;
    word_next  = word_reg;
    acc_next   = acc_reg;
    words_next = words_reg;
    we_next    = 1'b0;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    cpu_next   = cpu_reg;
    done_next  = done_reg;
    err_next   = err_reg;
    if (byte_valid)              timer_next = '0;
    else if (timer_reg == TMAX)  timer_next = timer_reg;
    else                         timer_next = timer_reg + 1'b1;

    case (state_reg)
      IDLE, DONE, ERROR: begin
        if (byte_valid && byte_data == HDR_BYTE) begin
          state_next = CNT_LO;
          cpu_next   = 1'b0;
          done_next  = 1'b0;
          err_next   = 1'b0;
          words_next = '0;
          acc_next   = '0;
        end
      end
      CNT_LO: begin
        if (byte_valid) begin
          count_next[7:0] = byte_data;
          state_next      = CNT_HI;
        end
      end
      CNT_HI: begin
        if (byte_valid) begin
          count_next = count_full;
          idx_next   = '0;
          if (count_full == 16'd0 || 32'(count_full) > 32'(MAX_WORDS)) state_next = ERROR;
          else                                                        state_next = DATA;
        end
      end
      DATA: begin
        if (byte_valid) begin
          word_next[{idx_reg, 3'b000} +: 8] = byte_data;
          acc_next = acc_reg ^ byte_data;
          idx_next = idx_reg + 2'd1;
          if (idx_reg == 2'd3) begin
            we_next    = 1'b1;
            addr_next  = words_reg[ADDR_WIDTH-1:0];
            wdata_next = {byte_data, word_reg[23:0]};
            words_next = words_reg + 16'd1;
            if (words_reg + 16'd1 == count_reg) state_next = CSUM;
          end
        end
      end
      CSUM: begin
        if (byte_valid) state_next = (byte_data == acc_reg) ? DONE : ERROR;
      end
      default: state_next = IDLE;
    endcase

    if (active && !byte_valid && (frame_err || timer_reg == TMAX)) state_next = ERROR;

    if (state_next == DONE && state_reg != DONE) begin
      done_next = 1'b1;
      cpu_next  = 1'b1;
    end
    if (state_next == ERROR && state_reg != ERROR) begin
      err_next = 1'b1;
      cpu_next = 1'b0;
    end
  end

  assign imem.we      = we_reg;
  assign imem.addr    = addr_reg;
  assign imem.wdata   = wdata_reg;
  assign cpu_reset_n  = cpu_reg;
  assign load_done    = done_reg;
  assign load_err     = err_reg;
  assign words_loaded = words_reg;

endmodule

// File: tb/tb_imem_uart_loader.sv
// Self-checking bench for the UART boot loader: hand-written corner cases plus
// a table of randomized frames checked against a frame-level reference model.
module tb_imem_uart_loader;
  import imem_loader_pkg::*;

  localparam int CPB  = 8;
  localparam int AW   = 10;
  localparam int MAXW = 1024;
  localparam int TMO  = 2000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        uart_rx = 1'b1;
  logic        cpu_reset_n, load_done, load_err;
  logic [15:0] words_loaded;

  imem_uart_loader_if #(.ADDR_WIDTH(AW)) imem ();

  imem_uart_loader #(
    .CLKS_PER_BIT(CPB), .ADDR_WIDTH(AW), .MAX_WORDS(MAXW), .TIMEOUT_CLKS(TMO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .uart_rx(uart_rx), .imem(imem),
    .cpu_reset_n(cpu_reset_n), .load_done(load_done), .load_err(load_err),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;
  logic [7:0]  frame_q[$];
  logic [41:0] wr_q[$];
  logic [41:0] exp_q[$];
  logic        we_prev = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Capture every write and require the strobe never to last two cycles.
  always @(negedge clk) begin
    if (imem.we === 1'b1) begin
      wr_q.push_back({imem.addr, imem.wdata});
      chk("we_one_cycle", {63'd0, we_prev}, 64'd0);
    end
    we_prev = imem.we;
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    uart_rx = 1'b0;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(posedge clk);
    end
    uart_rx = stop;
    repeat (CPB) @(posedge clk);
    uart_rx = 1'b1;
    repeat (CPB) @(posedge clk);
  endtask

  task automatic send_range(input int from, input int upto);
    for (int i = from; i < upto; i++) send_byte(frame_q[i], 1'b1);
  endtask

  task automatic build_frame(input int cnt, input int ndata, input bit bad);
    int n;
    logic [7:0] x, b;
    logic [15:0] c16;
    c16 = 16'(cnt);
    frame_q.delete();
    frame_q.push_back(HDR_BYTE);
    frame_q.push_back(c16[7:0]);
    frame_q.push_back(c16[15:8]);
    n = (ndata >= 0) ? ndata : ((cnt >= 1 && cnt <= MAXW) ? 4 * cnt : 0);
    x = 8'd0;
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom_range(0, 255));
      frame_q.push_back(b);
      x ^= b;
    end
    if (ndata < 0 && n > 0) frame_q.push_back(x ^ {7'd0, bad});
  endtask

  // Frame-level model: which words a frame writes and whether it verifies.
  function automatic void model_frame(output logic e_done, output logic e_err, output int e_words);
    int cnt, ndat, nw;
    logic [7:0] x;
    logic [31:0] w;
    exp_q.delete();
    e_done = 1'b0;
    e_err = 1'b1;
    e_words = 0;
    if (frame_q[OFS_HEADER] != HDR_BYTE) return;
    cnt = int'(frame_q[OFS_CNT_LO]) + 256 * int'(frame_q[OFS_CNT_HI]);
    if (cnt == 0 || cnt > MAXW) return;
    ndat = frame_q.size() - OFS_DATA;
    if (ndat > 4 * cnt) ndat = 4 * cnt;
    nw = ndat / 4;
    x = 8'd0;
    for (int i = 0; i < ndat; i++) x ^= frame_q[OFS_DATA + i];
    for (int k = 0; k < nw; k++) begin
      w = {frame_q[OFS_DATA+4*k+3], frame_q[OFS_DATA+4*k+2],
           frame_q[OFS_DATA+4*k+1], frame_q[OFS_DATA+4*k]};
      exp_q.push_back({AW'(k), w});
    end
    e_words = nw;
    if (frame_q.size() == OFS_DATA + 4 * cnt + 1 && frame_q[frame_q.size()-1] == x) begin
      e_done = 1'b1;
      e_err = 1'b0;
    end
  endfunction

  task automatic check_frame(input string tag);
    logic ed, ee;
    int ew, n;
    model_frame(ed, ee, ew);
    @(negedge clk);
    chk({tag, ".load_done"}, {63'd0, load_done}, {63'd0, ed});
    chk({tag, ".load_err"}, {63'd0, load_err}, {63'd0, ee});
    chk({tag, ".cpu_reset_n"}, {63'd0, cpu_reset_n}, {63'd0, ed});
    chk({tag, ".words_loaded"}, {48'd0, words_loaded}, 64'(ew));
    chk({tag, ".write_count"}, 64'(wr_q.size()), 64'(exp_q.size()));
    n = (wr_q.size() < exp_q.size()) ? wr_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk({tag, ".write"}, {22'd0, wr_q[i]}, {22'd0, exp_q[i]});
    $display("frame %s: done=%0d err=%0d words=%0d writes=%0d", tag, load_done, load_err,
             words_loaded, wr_q.size());
  endtask

  typedef struct {
    int   cnt;
    int   ndata;
    bit   bad;
    logic exp_done;
    logic exp_err;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{cnt: 1,     ndata: -1, bad: 1'b0, exp_done: 1'b1, exp_err: 1'b0};
    vecs[1] = '{cnt: 3,     ndata: -1, bad: 1'b1, exp_done: 1'b0, exp_err: 1'b1};
    vecs[2] = '{cnt: 1025,  ndata: -1, bad: 1'b0, exp_done: 1'b0, exp_err: 1'b1};
    vecs[3] = '{cnt: 5,     ndata: -1, bad: 1'b0, exp_done: 1'b1, exp_err: 1'b0};
    vecs[4] = '{cnt: 0,     ndata: -1, bad: 1'b0, exp_done: 1'b0, exp_err: 1'b1};
    vecs[5] = '{cnt: 2,     ndata: 5,  bad: 1'b0, exp_done: 1'b0, exp_err: 1'b1};
    vecs[6] = '{cnt: 4,     ndata: -1, bad: 1'b0, exp_done: 1'b1, exp_err: 1'b0};

    // Reset values.
    repeat (3) @(negedge clk);
    chk("rst.imem_we", {63'd0, imem.we}, 64'd0);
    chk("rst.imem_addr", 64'(imem.addr), 64'd0);
    chk("rst.imem_wdata", 64'(imem.wdata), 64'd0);
    chk("rst.cpu_reset_n", {63'd0, cpu_reset_n}, 64'd0);
    chk("rst.load_done", {63'd0, load_done}, 64'd0);
    chk("rst.load_err", {63'd0, load_err}, 64'd0);
    chk("rst.words_loaded", {48'd0, words_loaded}, 64'd0);
    reset_n = 1'b1;
    repeat (100) @(posedge clk);
    chk("idle.no_write", 64'(wr_q.size()), 64'd0);
    chk("idle.cpu_reset_n", {63'd0, cpu_reset_n}, 64'd0);

    // Stray byte in IDLE is ignored.
    send_byte(8'h5A, 1'b1);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("stray.no_write", 64'(wr_q.size()), 64'd0);
    chk("stray.load_err", {63'd0, load_err}, 64'd0);
    chk("stray.load_done", {63'd0, load_done}, 64'd0);
    $display("stray 0x5A: done=%0d err=%0d", load_done, load_err);

    // Known two-word image; the XOR of its eight data bytes is 0xB0.
    frame_q = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00,
                8'h93, 8'h05, 8'h20, 8'h00, 8'hB0};
    wr_q.delete();
    send_range(0, frame_q.size());
    repeat (10) @(posedge clk);
    check_frame("normal");
    chk("normal.word0", (wr_q.size() > 0) ? {22'd0, wr_q[0]} : 64'd0, {22'd0, 10'd0, 32'h00100513});
    chk("normal.word1", (wr_q.size() > 1) ? {22'd0, wr_q[1]} : 64'd0, {22'd0, 10'd1, 32'h00200593});

    frame_q[11] = 8'h21;
    wr_q.delete();
    send_range(0, frame_q.size());
    repeat (10) @(posedge clk);
    check_frame("bad_csum");

    frame_q = '{8'hA5, 8'h00, 8'h00};
    wr_q.delete();
    send_range(0, 3);
    repeat (10) @(posedge clk);
    check_frame("count_zero");
    frame_q = '{8'hA5, 8'h01, 8'h04};
    wr_q.delete();
    send_range(0, 3);
    repeat (10) @(posedge clk);
    check_frame("count_1025");

    // Short low glitch in the middle of a frame must not become a byte.
    build_frame(1, -1, 1'b0);
    wr_q.delete();
    send_range(0, 4);
    uart_rx = 1'b0;
    repeat (2) @(posedge clk);
    uart_rx = 1'b1;
    repeat (3 * CPB) @(posedge clk);
    send_range(4, frame_q.size());
    repeat (10) @(posedge clk);
    check_frame("glitch");

    // Bad stop bit inside DATA aborts long before the idle timeout.
    build_frame(2, 2, 1'b0);
    wr_q.delete();
    send_range(0, frame_q.size());
    send_byte(8'h3C, 1'b0);
    repeat (10) @(posedge clk);
    check_frame("stop_bit");

    for (int v = 0; v < 7; v++) begin
      build_frame(vecs[v].cnt, vecs[v].ndata, vecs[v].bad);
      wr_q.delete();
      send_range(0, frame_q.size());
      repeat ((vecs[v].ndata >= 0) ? TMO + 100 : 10) @(posedge clk);
      check_frame($sformatf("vec%0d", v));
      chk($sformatf("vec%0d.table_done", v), {63'd0, load_done}, {63'd0, vecs[v].exp_done});
      chk($sformatf("vec%0d.table_err", v), {63'd0, load_err}, {63'd0, vecs[v].exp_err});
    end

    // A new header while in DONE drops the core reset one cycle after byte_valid.
    fork
      send_byte(HDR_BYTE, 1'b1);
      begin
        int n;
        n = 0;
        @(negedge clk);
        while (dut.u_rx.byte_valid !== 1'b1 && n < 400) begin
          @(negedge clk);
          n++;
        end
        chk("restart.byte_seen", {63'd0, dut.u_rx.byte_valid}, 64'd1);
        chk("restart.cpu_before", {63'd0, cpu_reset_n}, 64'd1);
        @(negedge clk);
        chk("restart.cpu_after", {63'd0, cpu_reset_n}, 64'd0);
        chk("restart.done_after", {63'd0, load_done}, 64'd0);
        $display("restart: cpu_reset_n=%0d load_done=%0d", cpu_reset_n, load_done);
      end
    join

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
